lcd_spi_write: RTL



---
 rtl/lcd_pkg.sv | 16 +
 rtl/lcd_spi_phase.sv | 39 +++
 rtl/lcd_spi_write.sv | 110 +++++++++++
 3 files changed

// File: rtl/lcd_pkg.sv
// rtl/lcd_pkg.sv - shared word layout, idle word and SPI state encoding for the LCD write path
package lcd_pkg;

    localparam int LCD_WORD_W = 9;
    localparam int LCD_DC_BIT = 8;

    localparam logic [LCD_WORD_W-1:0] DATA_IDLE = 9'h100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2,
        ST_GAP   = 2'd3
    } spi_state_e;

endpackage

// File: rtl/lcd_spi_phase.sv
// rtl/lcd_spi_phase.sv - half-period counter producing SCLK rise/fall strobes every CLK_DIV cycles
module lcd_spi_phase #(
    parameter int CLK_DIV = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic run_i,
    output logic rise_o,
    output logic fall_o
);

    localparam int CNT_W = $clog2(CLK_DIV) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic             high_q;
    logic             half_end;

    assign half_end = run_i && (cnt_q == CNT_LAST);
    assign rise_o   = half_end && !high_q;
    assign fall_o   = half_end && high_q;

    // Counter and phase are parked at zero outside a transfer so every byte starts low.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt_q  <= '0;
            high_q <= 1'b0;
        end else if (!run_i) begin
            cnt_q  <= '0;
            high_q <= 1'b0;
        end else if (cnt_q == CNT_LAST) begin
            cnt_q  <= '0;
            high_q <= !high_q;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/lcd_spi_write.sv
// rtl/lcd_spi_write.sv - ST7735 byte transmitter: SPI mode 0, MSB first, one wr_done pulse per byte
module lcd_spi_write
    import lcd_pkg::*;
#(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 2
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  en_write,
    input  logic [LCD_WORD_W-1:0] data,
    output logic                  wr_done,
    output logic                  lcd_cs_n,
    output logic                  lcd_sclk,
    output logic                  lcd_mosi,
    output logic                  lcd_dc
);

    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES - 1);

    spi_state_e        state_q;
    logic [7:0]        shift_q;
    logic [2:0]        bit_q;
    logic [GAP_W-1:0]  gap_q;
    logic              wr_done_q;
    logic              cs_n_q;
    logic              sclk_q;
    logic              mosi_q;
    logic              dc_q;
    logic              run;
    logic              rise;
    logic              fall;

    assign run = (state_q == ST_SHIFT);

    lcd_spi_phase #(
        .CLK_DIV (CLK_DIV)
    ) u_phase (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .run_i     (run),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_q     <= '0;
            gap_q     <= '0;
            wr_done_q <= 1'b0;
            cs_n_q    <= 1'b1;
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            dc_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (en_write) begin
                        shift_q <= data[LCD_DC_BIT-1:0];
                        dc_q    <= data[LCD_DC_BIT];
                        mosi_q  <= data[LCD_DC_BIT-1];
                        cs_n_q  <= 1'b0;
                        bit_q   <= '0;
                        state_q <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (rise) begin
                        sclk_q <= 1'b1;
                    end else if (fall) begin
                        sclk_q <= 1'b0;
                        if (bit_q == 3'd7) begin
                            wr_done_q <= 1'b1;
                            cs_n_q    <= 1'b1;
                            state_q   <= ST_DONE;
                        end else begin
                            // Rotate rather than shift; the MSB slot is never driven again.
                            bit_q   <= bit_q + 1'b1;
                            mosi_q  <= shift_q[6];
                            shift_q <= {shift_q[6:0], shift_q[7]};
                        end
                    end
                end
                ST_DONE: begin
                    wr_done_q <= 1'b0;
                    gap_q     <= '0;
                    state_q   <= ST_GAP;
                end
                ST_GAP: begin
                    if (gap_q == GAP_LAST) begin
                        state_q <= ST_IDLE;
                    end else begin
                        gap_q <= gap_q + 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign wr_done  = wr_done_q;
    assign lcd_cs_n = cs_n_q;
    assign lcd_sclk = sclk_q;
    assign lcd_mosi = mosi_q;
    assign lcd_dc   = dc_q;

endmodule
